// File: rtl/player_ctrl.sv
// player_ctrl: player-side controller for the adventure game.
// Debounces the four direction buttons, merges near-simultaneous presses into a
// single one-cycle N/S/E/W move strobe, tracks the vorpal sword bit and locks
// out moves once the room FSM reports a win or a death.
// Optional move budget: define PLAYER_CTRL_MOVE_LIMIT_EN to end the game after
// MOVE_LIMIT moves (reported on timeout). Without it timeout is tied low.
module player_ctrl #(
   parameter int STABLE_CYCLES = 4,
   parameter int GATHER_CYCLES = 3,
   parameter int CNT_W         = 8,
   parameter int MOVE_LIMIT    = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_n,
   input  logic             btn_s,
   input  logic             btn_e,
   input  logic             btn_w,
   input  logic             sw,
   input  logic             win,
   input  logic             death,
   output logic             N,
   output logic             S,
   output logic             E,
   output logic             W,
   output logic             v,
   output logic [CNT_W-1:0] moves,
   output logic             game_over,
   output logic             timeout
);

   localparam int DB_W = $clog2(STABLE_CYCLES + 1);
   localparam int GC_W = $clog2(GATHER_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      GATHER,
      FIRE,
      WAIT_REL,
      OVER
   } state_t;

   // Button vectors are always ordered {n, s, e, w}.
   logic [3:0] btn_raw;

   logic [3:0]            sync1_q, sync1_d;
   logic [3:0]            sync2_q, sync2_d;
   logic [3:0]            deb_q, deb_d;
   logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

   state_t                state_q, state_d;
   logic [GC_W-1:0]       gcnt_q, gcnt_d;
   logic [3:0]            acc_q, acc_d;
   logic [3:0]            strobe_q, strobe_d;
   logic [CNT_W-1:0]      moves_q, moves_d;
   logic                  v_q, v_d;
   logic [CNT_W-1:0]      moves_inc;

   assign btn_raw = {btn_n, btn_s, btn_e, btn_w};

   // Two-flop synchronizer stage inputs for the asynchronous buttons.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
   end

   // Per-button debounce: the level flips only after STABLE_CYCLES straight disagreeing samples.
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_W'(STABLE_CYCLES - 1)) begin
               deb_d[i]    = sync2_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Synchronizer and debounce registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         deb_q    <= '0;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         deb_q    <= deb_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // Saturating increment of the move counter.
   assign moves_inc = (moves_q == {CNT_W{1'b1}}) ? moves_q : (moves_q + CNT_W'(1));

`ifdef PLAYER_CTRL_MOVE_LIMIT_EN
   logic timeout_q, timeout_d;

   // Move-FSM next state and registered outputs, including the move budget.
   always_comb begin
      state_d   = state_q;
      gcnt_d    = gcnt_q;
      acc_d     = acc_q;
      strobe_d  = '0;
      moves_d   = moves_q;
      timeout_d = timeout_q;
      v_d       = v_q | sw;
      case (state_q)
         IDLE: begin
            if (deb_q != 4'b0000) begin
               state_d = GATHER;
               acc_d   = deb_q;
               gcnt_d  = GC_W'(1);
            end
         end
         GATHER: begin
            acc_d = acc_q | deb_q;
            if (gcnt_q == GC_W'(GATHER_CYCLES)) begin
               state_d  = FIRE;
               strobe_d = acc_q | deb_q;
               moves_d  = moves_inc;
            end else begin
               gcnt_d = gcnt_q + GC_W'(1);
            end
         end
         FIRE: begin
            if (moves_q == CNT_W'(MOVE_LIMIT)) begin
               state_d   = OVER;
               timeout_d = 1'b1;
            end else begin
               state_d = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (deb_q == 4'b0000) begin
               state_d = IDLE;
            end
         end
         OVER: begin
            state_d = OVER;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A win or death ends the game ahead of anything else; it is not a timeout.
      if (win || death) begin
         state_d   = OVER;
         strobe_d  = '0;
         moves_d   = moves_q;
         timeout_d = timeout_q;
      end
   end

   // Timeout flag register, held until reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   // Move-FSM next state and registered outputs (no move budget).
   always_comb begin
      state_d  = state_q;
      gcnt_d   = gcnt_q;
      acc_d    = acc_q;
      strobe_d = '0;
      moves_d  = moves_q;
      v_d      = v_q | sw;
      case (state_q)
         IDLE: begin
            if (deb_q != 4'b0000) begin
               state_d = GATHER;
               acc_d   = deb_q;
               gcnt_d  = GC_W'(1);
            end
         end
         GATHER: begin
            acc_d = acc_q | deb_q;
            if (gcnt_q == GC_W'(GATHER_CYCLES)) begin
               state_d  = FIRE;
               strobe_d = acc_q | deb_q;
               moves_d  = moves_inc;
            end else begin
               gcnt_d = gcnt_q + GC_W'(1);
            end
         end
         FIRE: begin
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (deb_q == 4'b0000) begin
               state_d = IDLE;
            end
         end
         OVER: begin
            state_d = OVER;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A win or death ends the game ahead of anything else.
      if (win || death) begin
         state_d  = OVER;
         strobe_d = '0;
         moves_d  = moves_q;
      end
   end

   assign timeout = 1'b0;
`endif

   // Move-FSM state and registered output flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         gcnt_q   <= '0;
         acc_q    <= '0;
         strobe_q <= '0;
         moves_q  <= '0;
         v_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         gcnt_q   <= gcnt_d;
         acc_q    <= acc_d;
         strobe_q <= strobe_d;
         moves_q  <= moves_d;
         v_q      <= v_d;
      end
   end

   assign N         = strobe_q[3];
   assign S         = strobe_q[2];
   assign E         = strobe_q[1];
   assign W         = strobe_q[0];
   assign v         = v_q;
   assign moves     = moves_q;
   assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed bench for player_ctrl with a strobe scoreboard.
// Expected strobes (vector and cycle) are queued when a press is driven and
// matched by a negedge monitor whenever the DUT raises any of N/S/E/W.
// With PLAYER_CTRL_MOVE_LIMIT_EN defined the move budget is also exercised.
module tb_player_ctrl;

   localparam int STABLE = 4;
   localparam int GATHER = 3;
   localparam int CW     = 8;
   localparam int LIMIT  = 5;
   localparam int LAT    = 2 + STABLE + GATHER + 1;

   logic          clk;
   logic          reset;
   logic          btn_n, btn_s, btn_e, btn_w;
   logic          sw, win, death;
   logic          N, S, E, W;
   logic          v;
   logic [CW-1:0] moves;
   logic          game_over;
   logic          timeout;

   int            cyc;
   int            checks;
   int            failures;
   logic [3:0]    exp_vec_q[$];
   int            exp_cyc_q[$];

   player_ctrl #(
      .STABLE_CYCLES(STABLE),
      .GATHER_CYCLES(GATHER),
      .CNT_W(CW),
      .MOVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_n(btn_n),
      .btn_s(btn_s),
      .btn_e(btn_e),
      .btn_w(btn_w),
      .sw(sw),
      .win(win),
      .death(death),
      .N(N),
      .S(S),
      .E(E),
      .W(W),
      .v(v),
      .moves(moves),
      .game_over(game_over),
      .timeout(timeout)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Rising-edge counter used to time expected strobes.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyReset();
      reset = 1'b0;
      {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
      sw = 1'b0; win = 1'b0; death = 1'b0;
      waitCycles(3);
      reset = 1'b1;
      waitCycles(1);
   endtask

   // Press a button set for 'hold' cycles, release and let it settle.
   task automatic applyStimulus(input logic [3:0] btns, input int hold,
                                input logic [3:0] exp_vec, input bit expect_strobe);
      {btn_n, btn_s, btn_e, btn_w} = btns;
      if (expect_strobe) begin
         exp_vec_q.push_back(exp_vec);
         exp_cyc_q.push_back(cyc + LAT);
      end
      waitCycles(hold);
      {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
      waitCycles(16);
   endtask

   // Scoreboard monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if ({N, S, E, W} != 4'b0000) begin
         if (exp_vec_q.size() > 0) begin
            checkOutput("strobe_vec", {28'd0, N, S, E, W}, {28'd0, exp_vec_q.pop_front()});
            checkOutput("strobe_cycle", cyc, exp_cyc_q.pop_front());
         end else begin
            checkOutput("unexpected_strobe", {28'd0, N, S, E, W}, 32'd0);
         end
      end
   end

   // Directed sequence.
   initial begin
      cyc = 0; checks = 0; failures = 0;
      reset = 1'b0;
      {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
      sw = 1'b0; win = 1'b0; death = 1'b0;

      // Reset state after idling.
      applyReset();
      waitCycles(10);
      checkOutput("rst_nsew", {28'd0, N, S, E, W}, 32'd0);
      checkOutput("rst_v", {31'd0, v}, 32'd0);
      checkOutput("rst_moves", {24'd0, moves}, 32'd0);
      checkOutput("rst_game_over", {31'd0, game_over}, 32'd0);
      checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);

      // East held 20 cycles gives one strobe; a re-press gives one more.
      applyStimulus(4'b0010, 20, 4'b0010, 1'b1);
      checkOutput("east_moves", {24'd0, moves}, 32'd1);
      applyStimulus(4'b0010, 12, 4'b0010, 1'b1);
      checkOutput("east_repress_moves", {24'd0, moves}, 32'd2);

      // East then south two cycles later merge into one move.
      applyReset();
      btn_e = 1'b1;
      exp_vec_q.push_back(4'b0110);
      exp_cyc_q.push_back(cyc + LAT);
      waitCycles(2);
      btn_s = 1'b1;
      waitCycles(18);
      {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
      waitCycles(16);
      checkOutput("combo_moves", {24'd0, moves}, 32'd1);

      // Short north glitch never becomes a move.
      applyReset();
      applyStimulus(4'b1000, 3, 4'b0000, 1'b0);
      checkOutput("glitch_moves", {24'd0, moves}, 32'd0);
      checkOutput("glitch_state", {31'd0, game_over}, 32'd0);

      // Sword pickup, then death locks out further moves.
      sw = 1'b1;
      waitCycles(1);
      sw = 1'b0;
      checkOutput("sword_set", {31'd0, v}, 32'd1);
      waitCycles(5);
      checkOutput("sword_hold", {31'd0, v}, 32'd1);
      death = 1'b1;
      waitCycles(1);
      death = 1'b0;
      checkOutput("death_over", {31'd0, game_over}, 32'd1);
      applyStimulus(4'b0001, 12, 4'b0000, 1'b0);
      checkOutput("over_moves", {24'd0, moves}, 32'd0);
      checkOutput("over_still", {31'd0, game_over}, 32'd1);
      checkOutput("over_sword", {31'd0, v}, 32'd1);
      checkOutput("over_timeout", {31'd0, timeout}, 32'd0);

      // Reset clears the sword; a win during FIRE still lets the strobe out.
      applyReset();
      checkOutput("rst2_v", {31'd0, v}, 32'd0);
      checkOutput("rst2_game_over", {31'd0, game_over}, 32'd0);
      btn_e = 1'b1;
      exp_vec_q.push_back(4'b0010);
      exp_cyc_q.push_back(cyc + LAT);
      waitCycles(LAT);
      win = 1'b1;
      waitCycles(1);
      win = 1'b0;
      checkOutput("win_over", {31'd0, game_over}, 32'd1);
      checkOutput("win_moves", {24'd0, moves}, 32'd1);
      checkOutput("win_timeout", {31'd0, timeout}, 32'd0);
      btn_e = 1'b0;
      waitCycles(16);

`ifdef PLAYER_CTRL_MOVE_LIMIT_EN
      // Move budget: LIMIT presses, then the game times out.
      applyReset();
      for (int i = 0; i < LIMIT; i++) begin
         applyStimulus(4'b1000, 12, 4'b1000, 1'b1);
      end
      checkOutput("limit_moves", {24'd0, moves}, LIMIT);
      checkOutput("limit_over", {31'd0, game_over}, 32'd1);
      checkOutput("limit_timeout", {31'd0, timeout}, 32'd1);
      applyStimulus(4'b1000, 12, 4'b0000, 1'b0);
      checkOutput("limit_frozen", {24'd0, moves}, LIMIT);
      applyReset();
      checkOutput("limit_rst_timeout", {31'd0, timeout}, 32'd0);
      checkOutput("limit_rst_over", {31'd0, game_over}, 32'd0);
      checkOutput("limit_rst_moves", {24'd0, moves}, 32'd0);
`endif

      checkOutput("scoreboard_empty", exp_vec_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
